multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I-subset datapath: steps each instruction through

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 59 +++++
 rtl/multicycle_ctrl_fsm_if.sv | 37 +++
 rtl/multicycle_ctrl_fsm_alu_decoder.sv | 70 +++++++
 rtl/multicycle_ctrl_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : multicycle_ctrl_fsm_pkg
//  Purpose : Shared constants and types for the multi-cycle RV32I-subset
//            control sequencer: opcodes, ALU control codes, FSM state
//            encoding and instruction-class helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package multicycle_ctrl_fsm_pkg;

  // Supported major opcodes
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU control codes driven towards the datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // Coarse instruction class, decides the path after EXEC
  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LW  = 2'd1,
    CLS_SW  = 2'd2,
    CLS_BEQ = 2'd3
  } op_class_t;

  // Unsupported opcodes fall into CLS_ALU; they never reach EXEC because
  // DECODE diverts them to ERROR.
  function automatic op_class_t op_class(input logic [6:0] opcode);
    op_class_t cls;
    cls = CLS_ALU;
    case (opcode)
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      default: cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module  : multicycle_ctrl_fsm_if
//  Purpose : Request/ready handshake between the control sequencer and the
//            unified variable-latency memory.
//  Signals : mem_req   access request, held until mem_ready
//            mem_read  access is a read (fetch or LW)
//            mem_write access is a write (SW)
//            iord      0 = address from PC, 1 = address from ALU result
//            mem_ready memory completes the access this cycle
//  Modports: master (sequencer side), slave (memory side)
//  Rev     : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_fsm_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_read,
    output mem_write,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_read,
    input  mem_write,
    input  iord,
    output mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module  : multicycle_ctrl_fsm_alu_decoder
//  Purpose : Combinational decode of opcode/funct3/instr[30] into the ALU
//            operation, ALU B-operand select and a legality flag.
//  Ports   : opcode      in  7  instr[6:0]
//            funct3      in  3  instr[14:12]
//            funct7_b5   in  1  instr[30] (selects SUB for R-type)
//            alu_control out 4  ALU operation code
//            alu_src     out 1  0 = rs2, 1 = immediate
//            legal       out 1  opcode/funct3 combination is supported
//  Rev     : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm_alu_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  wire logic [6:0] opcode,
  input  wire logic [2:0] funct3,
  input  wire logic       funct7_b5,
  output logic      [3:0] alu_control,
  output logic            alu_src,
  output logic            legal
);

  // Shared funct3 table for R-type and I-ALU; SUB only exists for R-type
  // since bit 30 of an I-type word is immediate data.
  logic [3:0] f3_alu;
  logic       f3_legal;

  always_comb begin
    f3_alu   = ALU_ADD;
    f3_legal = 1'b1;
    case (funct3)
      3'b000:  f3_alu = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b111:  f3_alu = ALU_AND;
      3'b110:  f3_alu = ALU_OR;
      3'b010:  f3_alu = ALU_SLT;
      default: f3_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    alu_src     = 1'b0;
    legal       = 1'b0;
    case (opcode)
      OP_R: begin
        alu_control = f3_alu;
        legal       = f3_legal;
      end
      OP_I: begin
        alu_control = f3_alu;
        alu_src     = 1'b1;
        legal       = f3_legal;
      end
      OP_LW, OP_SW: begin
        alu_control = ALU_ADD;
        alu_src     = 1'b1;
        legal       = 1'b1;
      end
      OP_BEQ: begin
        alu_control = ALU_SUB;
        legal       = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : multicycle_ctrl_fsm
//  Purpose : Multi-cycle sequencer for the RV32I-subset datapath. Steps each
//            instruction through FETCH/DECODE/EXEC/MEM/WB, drives datapath
//            strobes, handshakes with a variable-latency memory, counts
//            retired instructions and traps on illegal opcodes or timeout.
//  Params  : CNT_W   retired-instruction counter width (wraps)
//            TIMEOUT max wait cycles for mem_ready, 0 disables the timeout
//  Ports   : clk, reset (async, active-high)
//            mem          memory handshake (master modport)
//            instr[31:0]  IR contents; zero = ALU zero flag (EXEC)
//            ir_write, pc_inc, pc_branch, alu_control[3:0], alu_src,
//            reg_write, mem_to_reg  datapath strobes
//            retire, retired_cnt[CNT_W-1:0]  retirement pulse and count
//            illegal, mem_timeout  sticky trap flags
//  Rev     : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  multicycle_ctrl_fsm_if.master     mem,
  input  wire logic [31:0]          instr,
  input  wire logic                 zero,
  output logic                      ir_write,
  output logic                      pc_inc,
  output logic                      pc_branch,
  output logic      [3:0]           alu_control,
  output logic                      alu_src,
  output logic                      reg_write,
  output logic                      mem_to_reg,
  output logic                      retire,
  output logic      [CNT_W-1:0]     retired_cnt,
  output logic                      illegal,
  output logic                      mem_timeout
);

  // Wait counter holds 0..TIMEOUT-1; the last value is the trap point.
  localparam int unsigned WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = TO_LAST[WAIT_W-1:0];

  state_t          state, next_state;
  op_class_t       dec_cls;
  logic [3:0]      dec_alu;
  logic            dec_src;
  logic [WAIT_W-1:0] wait_cnt;

  logic [3:0]      id_alu;
  logic            id_src;
  logic            id_legal;

  logic            mem_req_c, mem_read_c, mem_write_c, iord_c;
  logic            waiting;
  logic            timeout_hit;
  logic            set_illegal;
  logic            set_timeout;

  // Only these IR fields steer control; the rest belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  multicycle_ctrl_fsm_alu_decoder u_alu_decoder (
    .opcode      (instr[6:0]),
    .funct3      (instr[14:12]),
    .funct7_b5   (instr[30]),
    .alu_control (id_alu),
    .alu_src     (id_src),
    .legal       (id_legal)
  );

  assign waiting     = mem_req_c && !mem.mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  // --------------------------------------------------------------------------
  // Next-state and Moore outputs. mem_ready only gates the completing-cycle
  // strobes (ir_write, pc_inc, retire) and the state advance.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    mem_req_c   = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    iord_c      = 1'b0;
    ir_write    = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    alu_control = ALU_AND;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    case (state)
      IDLE: next_state = FETCH;

      FETCH: begin
        mem_req_c  = 1'b1;
        mem_read_c = 1'b1;
        if (mem.mem_ready) begin
          ir_write   = 1'b1;
          pc_inc     = 1'b1;
          next_state = DECODE;
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          next_state  = ERROR;
        end
      end

      DECODE: begin
        if (id_legal) begin
          next_state = EXEC;
        end else begin
          set_illegal = 1'b1;
          next_state  = ERROR;
        end
      end

      EXEC: begin
        alu_control = dec_alu;
        alu_src     = dec_src;
        case (dec_cls)
          CLS_BEQ: begin
            pc_branch  = zero;
            retire     = 1'b1;
            next_state = FETCH;
          end
          CLS_LW, CLS_SW: next_state = MEM;
          default:        next_state = WB;
        endcase
      end

      MEM: begin
        // Keep the address computation (base + imm) live for the whole
        // access since iord selects the ALU result as the address.
        mem_req_c   = 1'b1;
        iord_c      = 1'b1;
        alu_control = ALU_ADD;
        alu_src     = 1'b1;
        mem_read_c  = (dec_cls == CLS_LW);
        mem_write_c = (dec_cls == CLS_SW);
        if (mem.mem_ready) begin
          if (dec_cls == CLS_SW) begin
            retire     = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          next_state  = ERROR;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (dec_cls == CLS_LW);
        retire     = 1'b1;
        next_state = FETCH;
      end

      ERROR:   next_state = ERROR;
      default: next_state = ERROR;
    endcase
  end

  assign mem.mem_req   = mem_req_c;
  assign mem.mem_read  = mem_read_c;
  assign mem.mem_write = mem_write_c;
  assign mem.iord      = iord_c;

  // --------------------------------------------------------------------------
  // State register, latched decode, wait counter, retire counter, flags.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dec_cls     <= CLS_ALU;
      dec_alu     <= ALU_ADD;
      dec_src     <= 1'b0;
      wait_cnt    <= '0;
      retired_cnt <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= next_state;

      // Decode results are captured once so later IR churn cannot disturb
      // EXEC/MEM/WB of the instruction in flight.
      if (state == DECODE) begin
        dec_cls <= op_class(instr[6:0]);
        dec_alu <= id_alu;
        dec_src <= id_src;
      end

      // Any non-waiting cycle clears the counter, so every FETCH/MEM entry
      // starts from zero.
      if (waiting) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (retire) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end

      if (set_illegal) begin
        illegal <= 1'b1;
      end
      if (set_timeout) begin
        mem_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : tb_multicycle_ctrl_fsm
//  Purpose : Self-checking bench for multicycle_ctrl_fsm. Per-cycle vectors
//            of {instr, mem_ready, zero, expected strobes, expected flags}
//            applied from a table, plus hand-written corner sequences.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ORI  = 32'h0050E193;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_SLL  = 32'h002091B3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        ir_write, pc_inc, pc_branch, alu_src, reg_write, mem_to_reg, retire;
  logic [3:0]  alu_control;
  logic [3:0]  retired_cnt;
  logic        illegal, mem_timeout;

  multicycle_ctrl_fsm_if mif ();

  multicycle_ctrl_fsm #(.CNT_W(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mif.master),
    .instr       (instr),
    .zero        (zero),
    .ir_write    (ir_write),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .alu_control (alu_control),
    .alu_src     (alu_src),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .illegal     (illegal),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  // {req, rd, wr, iord, ir_write, pc_inc, pc_branch, alu[3:0], src, reg_write, mem_to_reg, retire}
  logic [14:0] got_s;
  assign got_s = {mif.mem_req, mif.mem_read, mif.mem_write, mif.iord, ir_write, pc_inc,
                  pc_branch, alu_control, alu_src, reg_write, mem_to_reg, retire};

  typedef struct {
    logic [31:0] instr;
    logic        rdy;
    logic        z;
    logic [14:0] s;
    logic        ill;
    logic        tmo;
  } vec_t;

  vec_t       vecs[$];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_cnt;

  function automatic logic [14:0] sv(input logic req, rd, wr, io, irw, pci, pcb,
                                     input logic [3:0] alu,
                                     input logic src, rw, m2r, ret);
    return {req, rd, wr, io, irw, pci, pcb, alu, src, rw, m2r, ret};
  endfunction

  function automatic logic [14:0] s_fw();  return sv(1,1,0,0,0,0,0,4'b0000,0,0,0,0); endfunction
  function automatic logic [14:0] s_fd();  return sv(1,1,0,0,1,1,0,4'b0000,0,0,0,0); endfunction
  function automatic logic [14:0] s_ex(input logic [3:0] a, input logic src);
    return sv(0,0,0,0,0,0,0,a,src,0,0,0);
  endfunction
  function automatic logic [14:0] s_wb(input logic m2r); return sv(0,0,0,0,0,0,0,4'b0000,0,1,m2r,1); endfunction
  function automatic logic [14:0] s_mem(input logic rd, wr, ret);
    return sv(1,rd,wr,1,0,0,0,4'b0010,1,0,0,ret);
  endfunction
  function automatic logic [14:0] s_beq(input logic pcb); return sv(0,0,0,0,0,0,pcb,4'b0110,0,0,0,1); endfunction

  task automatic add(input logic [31:0] ins, input logic rdy, z, input logic [14:0] s,
                     input logic ill, tmo);
    vec_t v;
    v.instr = ins; v.rdy = rdy; v.z = z; v.s = s; v.ill = ill; v.tmo = tmo;
    vecs.push_back(v);
  endtask

  // Four-cycle ALU instruction: FETCH (immediate ready), DECODE, EXEC, WB.
  // A stray mem_ready in DECODE must be ignored.
  task automatic add_alu(input logic [31:0] ins, input logic [3:0] a, input logic src);
    add(ins, 1, 0, s_fd(), 0, 0);
    add(ins, 1, 0, '0, 0, 0);
    add(ins, 0, 0, s_ex(a, src), 0, 0);
    add(ins, 0, 0, s_wb(0), 0, 0);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got, want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are compared on
  // the falling edge.
  task automatic run(input string tag);
    foreach (vecs[i]) begin
      instr         = vecs[i].instr;
      mif.mem_ready = vecs[i].rdy;
      zero          = vecs[i].z;
      @(negedge clk);
      chk({tag, " strobes"}, i, 32'(got_s), 32'(vecs[i].s));
      chk({tag, " flags"}, i, {30'd0, illegal, mem_timeout}, {30'd0, vecs[i].ill, vecs[i].tmo});
      chk({tag, " count"}, i, 32'(retired_cnt), 32'(exp_cnt));
      if (vecs[i].s[0]) exp_cnt++;
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    mif.mem_ready = 1'b0;
    zero          = 1'b0;
    instr         = 32'h0;
    exp_cnt       = '0;
    @(negedge clk);
    chk("reset strobes", 0, 32'(got_s), 32'd0);
    chk("reset flags", 0, {30'd0, illegal, mem_timeout}, 32'd0);
    chk("reset count", 0, 32'(retired_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- main program: every instruction class ----------------
    do_reset();
    add(I_ADD, 1, 0, '0, 0, 0);                 // IDLE, ready ignored
    add_alu(I_ADD, 4'b0010, 0);
    add_alu(I_SUB, 4'b0110, 0);
    add_alu(I_ORI, 4'b0001, 1);
    add_alu(I_AND, 4'b0000, 0);
    add_alu(I_SLT, 4'b0111, 0);
    // LW: 3 wait cycles in FETCH and in MEM -> 11 cycles total
    for (int k = 0; k < 3; k++) add(I_LW, 0, 0, s_fw(), 0, 0);
    add(I_LW, 1, 0, s_fd(), 0, 0);
    add(I_LW, 0, 0, '0, 0, 0);
    add(I_LW, 0, 0, s_ex(4'b0010, 1), 0, 0);
    for (int k = 0; k < 3; k++) add(I_LW, 0, 0, s_mem(1, 0, 0), 0, 0);
    add(I_LW, 1, 0, s_mem(1, 0, 0), 0, 0);
    add(I_LW, 0, 0, s_wb(1), 0, 0);
    // SW with single-cycle access retires from MEM
    add(I_SW, 1, 0, s_fd(), 0, 0);
    add(I_SW, 0, 0, '0, 0, 0);
    add(I_SW, 0, 0, s_ex(4'b0010, 1), 0, 0);
    add(I_SW, 1, 0, s_mem(0, 1, 1), 0, 0);
    // BEQ taken: zero high outside EXEC must not branch
    add(I_BEQ, 1, 1, s_fd(), 0, 0);
    add(I_BEQ, 0, 1, '0, 0, 0);
    add(I_BEQ, 0, 1, s_beq(1), 0, 0);
    // BEQ not taken still retires
    add(I_BEQ, 1, 0, s_fd(), 0, 0);
    add(I_BEQ, 0, 0, '0, 0, 0);
    add(I_BEQ, 0, 0, s_beq(0), 0, 0);
    run("prog");

    // ---------------- counter wrap: 9 + 7 = 16 -> 0 with CNT_W=4 -----------
    for (int k = 0; k < 7; k++) add_alu(I_ADD, 4'b0010, 0);
    run("wrap");
    chk("wrap to zero", 0, 32'(retired_cnt), 32'd0);

    // ---------------- illegal opcode 0x7F ----------------------------------
    do_reset();
    add(I_BAD, 0, 0, '0, 0, 0);
    add(I_BAD, 1, 0, s_fd(), 0, 0);
    add(I_BAD, 0, 0, '0, 0, 0);
    for (int k = 0; k < 4; k++) add(I_BAD, k[0], 1, '0, 1, 0);
    run("badop");

    // ---------------- R-type funct3 001 ------------------------------------
    do_reset();
    add(I_SLL, 0, 0, '0, 0, 0);
    add(I_SLL, 1, 0, s_fd(), 0, 0);
    add(I_SLL, 0, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++) add(I_ADD, 1, 0, '0, 1, 0);
    run("badf3");

    // ---------------- fetch timeout: 16 wait cycles then ERROR -------------
    do_reset();
    add(I_ADD, 0, 0, '0, 0, 0);
    for (int k = 0; k < 16; k++) add(I_ADD, 0, 0, s_fw(), 0, 0);
    for (int k = 0; k < 3; k++) add(I_ADD, k[0], 0, '0, 0, 1);
    run("timeout");

    // ---------------- asynchronous reset in the middle of MEM --------------
    do_reset();
    add(I_ADD, 0, 0, '0, 0, 0);
    add_alu(I_ADD, 4'b0010, 0);
    add(I_LW, 1, 0, s_fd(), 0, 0);
    add(I_LW, 0, 0, '0, 0, 0);
    add(I_LW, 0, 0, s_ex(4'b0010, 1), 0, 0);
    add(I_LW, 0, 0, s_mem(1, 0, 0), 0, 0);
    add(I_LW, 0, 0, s_mem(1, 0, 0), 0, 0);
    run("midmem");
    #2;
    chk("pre-reset mem_req", 0, {31'd0, mif.mem_req}, 32'd1);
    chk("pre-reset count", 0, 32'(retired_cnt), 32'd1);
    reset = 1'b1;
    #1;
    chk("async mem_req", 0, {31'd0, mif.mem_req}, 32'd0);
    chk("async strobes", 0, 32'(got_s), 32'd0);
    chk("async count", 0, 32'(retired_cnt), 32'd0);
    chk("async flags", 0, {30'd0, illegal, mem_timeout}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = '0;
    add(I_ADD, 0, 0, '0, 0, 0);
    add_alu(I_ADD, 4'b0010, 0);
    run("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
